stage_ex_mc: RTL and testbench

//  Parametrised multi-cycle EX stage of the MIPS 5-stage pipeline. Same operand selection, op

---
 rtl/ex_pkg.sv | 23 ++
 rtl/stage_ex_mdu_iter.sv | 74 +++++++
 rtl/stage_ex_mc.sv | 134 +++++++++++++
 tb/tb_stage_ex_mc.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the multi-cycle EX stage.
// Contains the ALU op codes and the EX sequencing state.
package ex_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1100;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b1001;
   localparam logic [3:0] OP_LUI = 4'b1101;
   localparam logic [3:0] OP_SLL = 4'b0010;
   localparam logic [3:0] OP_SRL = 4'b1110;
   localparam logic [3:0] OP_SRA = 4'b1010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } ex_state_t;

endpackage

// File: rtl/stage_ex_mdu_iter.sv
// Iterative multiply/divide unit: 1 bit per cycle, XLEN steps.
// Ports: clk, rst, start, op_div, a, b in; done, result, div_zero out.
module stage_ex_mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            op_div,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            div_zero
);

   localparam int SH_W = $clog2(XLEN);

   logic            run;
   logic            is_div;
   logic [SH_W-1:0] cnt;
   logic [XLEN-1:0] acc, x, y;
   logic [XLEN-1:0] acc_n, x_n, y_n;
   logic [XLEN:0]   r_sh;
   logic            ge;

   // MUL: acc += y when x[0]; x shifts right, y shifts left.
   // DIV: restoring step, quotient shifts into x, remainder in acc.
   // A zero divisor always subtracts, yielding an all-ones quotient.
   always_comb begin
      r_sh  = {acc, x[XLEN-1]};
      ge    = (r_sh >= {1'b0, y});
      acc_n = acc;
      x_n   = x;
      y_n   = y;
      if (is_div) begin
         acc_n = ge ? (r_sh[XLEN-1:0] - y) : r_sh[XLEN-1:0];
         x_n   = {x[XLEN-2:0], ge};
      end else begin
         acc_n = acc + (x[0] ? y : '0);
         x_n   = x >> 1;
         y_n   = y << 1;
      end
      result = is_div ? x_n : acc_n;
      done   = run && (cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run      <= 1'b0;
         is_div   <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         x        <= '0;
         y        <= '0;
         div_zero <= 1'b0;
      end else if (start) begin
         run      <= 1'b1;
         is_div   <= op_div;
         cnt      <= SH_W'(XLEN - 1);
         acc      <= '0;
         x        <= a;
         y        <= b;
         div_zero <= op_div && (b == '0);
      end else if (run) begin
         acc <= acc_n;
         x   <= x_n;
         y   <= y_n;
         cnt <= cnt - 1'b1;
         if (cnt == '0) run <= 1'b0;
      end
   end

endmodule

// File: rtl/stage_ex_mc.sv
// Multi-cycle EX stage: operand muxes, ALU, MUL/DIV sequencing, output register.
// Ports: clk, rst, ID handshake (in_valid/in_ready), op fields, MEM handshake, ans/rw/div_zero/busy.
module stage_ex_mc
   import ex_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RW_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic            aluimm,
   input  logic            shift,
   input  logic            jal,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc4,
   input  logic [RW_W-1:0] rw_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ans,
   output logic [RW_W-1:0] rw,
   output logic            div_zero,
   output logic            busy
);

   localparam int SH_W = $clog2(XLEN);

   ex_state_t       state;
   logic [RW_W-1:0] rw_hold;
   logic [XLEN-1:0] a_calc, b_calc, alu;
   logic [SH_W-1:0] sh;
   logic            fire_in, fire_out, is_iter, start;
   logic            mdu_done, mdu_dz;
   logic [XLEN-1:0] mdu_res;
   logic [RW_W-1:0] rw_next;

   assign in_ready = !busy && (!out_valid || out_ready);
   assign fire_in  = in_valid && in_ready;
   assign fire_out = out_valid && out_ready;
   assign is_iter  = !jal && (op == OP_MUL || op == OP_DIV);
   assign start    = fire_in && is_iter;
   assign rw_next  = rw_in | {RW_W{jal}};

   // Shift amount arrives in imm[10:6]; rotating right by 6 aligns it to bit 0.
   assign a_calc = shift ? {imm[5:0], imm[XLEN-1:6]} : a;
   assign b_calc = aluimm ? imm : b;
   assign sh     = a_calc[SH_W-1:0];

   always_comb begin
      alu = '0;
      if (jal) begin
         alu = pc4 + XLEN'(4);
      end else if (op[1:0] == 2'b11) begin
         alu = a_calc;
      end else begin
         case (op)
            OP_ADD:  alu = a_calc + b_calc;
            OP_SUB:  alu = a_calc - b_calc;
            OP_AND:  alu = a_calc & b_calc;
            OP_OR:   alu = a_calc | b_calc;
            OP_XOR:  alu = a_calc ^ b_calc;
            OP_LUI:  alu = {b_calc[XLEN/2-1:0], {(XLEN/2){1'b0}}};
            OP_SLL:  alu = b_calc << sh;
            OP_SRL:  alu = b_calc >> sh;
            OP_SRA:  alu = $signed(b_calc) >>> sh;
            default: alu = '0;
         endcase
      end
   end

   stage_ex_mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_div   (op == OP_DIV),
      .a        (a_calc),
      .b        (b_calc),
      .done     (mdu_done),
      .result   (mdu_res),
      .div_zero (mdu_dz)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         ans       <= '0;
         rw        <= '0;
         rw_hold   <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fire_out) out_valid <= 1'b0;
               if (fire_in) begin
                  if (is_iter) begin
                     rw_hold <= rw_next;
                     busy    <= 1'b1;
                     state   <= S_RUN;
                  end else begin
                     ans       <= alu;
                     rw        <= rw_next;
                     div_zero  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (mdu_done) begin
                  ans       <= mdu_res;
                  rw        <= rw_hold;
                  div_zero  <= mdu_dz;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (fire_out) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_ex_mc.sv
// Self-checking bench for stage_ex_mc (XLEN=32): vector table plus
// hand-written multi-cycle, backpressure and reset sequences.
module tb_stage_ex_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [3:0]  op;
   logic        aluimm, shift, jal;
   logic [31:0] a, b, imm, pc4;
   logic [4:0]  rw_in;
   logic        out_valid, out_ready;
   logic [31:0] ans;
   logic [4:0]  rw;
   logic        div_zero, busy;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stage_ex_mc #(.XLEN(32), .RW_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .aluimm(aluimm), .shift(shift), .jal(jal),
      .a(a), .b(b), .imm(imm), .pc4(pc4), .rw_in(rw_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .ans(ans), .rw(rw), .div_zero(div_zero), .busy(busy)
   );

   typedef struct {
      logic [3:0]  op;
      logic        aluimm;
      logic        shift;
      logic        jal;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rw_in;
      logic [31:0] e_ans;
      logic [4:0]  e_rw;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid = 1'b1;
      op = v.op; aluimm = v.aluimm; shift = v.shift; jal = v.jal;
      a = v.a; b = v.b; imm = v.imm; pc4 = v.pc4; rw_in = v.rw_in;
   endtask

   task automatic run_iter(input string nm, input logic [3:0] o,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] ea, input logic edz);
      int n;
      logic hold_ok;
      in_valid = 1'b1; op = o; aluimm = 1'b0; shift = 1'b0; jal = 1'b0;
      a = av; b = bv; imm = '0; pc4 = '0; rw_in = 5'd9; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({nm, "_busy_start"}, busy, 1);
      n = 0;
      hold_ok = 1'b1;
      while (!out_valid && n < 100) begin
         if (!busy || in_ready) hold_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, n, 32);
      chk({nm, "_busy_hold"}, hold_ok, 1);
      chk({nm, "_ans"}, ans, ea);
      chk({nm, "_dz"}, div_zero, edz);
      chk({nm, "_rw"}, rw, 9);
      chk({nm, "_ready_done"}, in_ready, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_drain_valid"}, out_valid, 0);
      chk({nm, "_drain_busy"}, busy, 0);
      chk({nm, "_drain_ready"}, in_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      logic gone;
      tbl[0]  = '{4'b0000, 0, 0, 0, 32'd5, 32'd7, 0, 0, 5'd3, 32'd12, 5'd3};
      tbl[1]  = '{4'b0100, 0, 0, 0, 32'd3, 32'd5, 0, 0, 5'd4, 32'hFFFFFFFE, 5'd4};
      tbl[2]  = '{4'b0001, 0, 0, 0, 32'hF0F0, 32'hFF00, 0, 0, 5'd5, 32'hF000, 5'd5};
      tbl[3]  = '{4'b0101, 0, 0, 0, 32'hF0, 32'h0F, 0, 0, 5'd6, 32'hFF, 5'd6};
      tbl[4]  = '{4'b1001, 0, 0, 0, 32'hFF, 32'h0F, 0, 0, 5'd7, 32'hF0, 5'd7};
      tbl[5]  = '{4'b1101, 0, 0, 0, 0, 32'h1234, 0, 0, 5'd8, 32'h12340000, 5'd8};
      tbl[6]  = '{4'b0010, 0, 0, 0, 32'd4, 32'd1, 0, 0, 5'd1, 32'h10, 5'd1};
      tbl[7]  = '{4'b1110, 0, 0, 0, 32'd4, 32'h80000000, 0, 0, 5'd2,
                  32'h08000000, 5'd2};
      tbl[8]  = '{4'b1010, 0, 1, 0, 32'd0, 32'h80000000, 32'h100, 0, 5'd10,
                  32'hF8000000, 5'd10};
      tbl[9]  = '{4'b0011, 0, 0, 0, 32'hDEAD, 32'd1, 0, 0, 5'd11, 32'hDEAD, 5'd11};
      tbl[10] = '{4'b0000, 1, 0, 0, 32'd1, 32'd99, 32'hFFFFFFFF, 0, 5'd12, 32'd0, 5'd12};
      tbl[11] = '{4'b1100, 0, 0, 1, 32'd100, 32'd7, 0, 32'h104, 5'd2, 32'h108, 5'd31};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; aluimm = 0; shift = 0; jal = 0;
      a = '0; b = '0; imm = '0; pc4 = '0; rw_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ans", ans, 0);
      chk("rst_rw", rw, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_ready", in_ready, 1);

      // back-to-back single-cycle ops, no bubbles
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("tbl%0d_ready", i), in_ready, 1);
         drive(tbl[i]);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_valid", i), out_valid, 1);
         chk($sformatf("tbl%0d_ans", i), ans, tbl[i].e_ans);
         chk($sformatf("tbl%0d_rw", i), rw, 32'(tbl[i].e_rw));
         chk($sformatf("tbl%0d_dz", i), div_zero, 0);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("tbl_drain_valid", out_valid, 0);

      run_iter("div100_7", 4'b1100, 32'd100, 32'd7, 32'd14, 1'b0);
      run_iter("mul_ffff", 4'b1000, 32'hFFFF, 32'h10001, 32'hFFFFFFFF, 1'b0);
      run_iter("mul_small", 4'b1000, 32'd12345, 32'd678, 32'd8369910, 1'b0);
      run_iter("div_big", 4'b1100, 32'hFFFFFFFF, 32'd3, 32'h55555555, 1'b0);
      run_iter("div_zero", 4'b1100, 32'd55, 32'd0, 32'hFFFFFFFF, 1'b1);

      // backpressure: result held, new op ignored, then drain+accept
      out_ready = 1'b0;
      v = '{4'b0000, 0, 0, 0, 32'd1, 32'd2, 0, 0, 5'd13, 32'd3, 5'd13};
      drive(v);
      @(posedge clk); #1;
      v = '{4'b1001, 0, 0, 0, 32'hAA, 32'h0F, 0, 0, 5'd14, 32'hA5, 5'd14};
      drive(v);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("bp%0d_ans", i), ans, 3);
         chk($sformatf("bp%0d_valid", i), out_valid, 1);
         chk($sformatf("bp%0d_ready", i), in_ready, 0);
      end
      chk("bp_rw", rw, 13);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_accept_valid", out_valid, 1);
      chk("bp_accept_ans", ans, 32'hA5);
      chk("bp_accept_rw", rw, 14);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_end_valid", out_valid, 0);

      // reset in the middle of a DIV
      v = '{4'b1100, 0, 0, 0, 32'd100, 32'd7, 0, 0, 5'd15, 32'd0, 5'd15};
      drive(v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ans", ans, 0);
      chk("mrst_ready", in_ready, 1);
      gone = 1'b1;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk); #1;
         if (out_valid || busy) gone = 1'b0;
      end
      chk("mrst_discard", gone, 1);
      v = '{4'b0000, 0, 0, 0, 32'd20, 32'd22, 0, 0, 5'd16, 32'd42, 5'd16};
      drive(v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_valid", out_valid, 1);
      chk("post_ans", ans, 42);
      chk("post_rw", rw, 16);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
